// File: rtl/hc194_seq_ctrl_if.sv
// Command-side bundle for hc194_seq_ctrl: request handshake plus the completion
// status (busy / done / q_out) returned to the requester.
interface hc194_seq_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_cnt;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_fill;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q_out;

  modport master (
    output cmd_valid, cmd_op, cmd_cnt, cmd_data, cmd_fill,
    input  cmd_ready, busy, done, q_out
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_cnt, cmd_data, cmd_fill,
    output cmd_ready, busy, done, q_out
  );
endinterface

// File: rtl/hc194_seq_ctrl.sv
// Command sequencer for a single 74HC194-style universal shift register on the
// same clock: drives S/DS/D for the requested number of cycles, then reports Q.
module hc194_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             CP,
  input  logic             CR_n,
  hc194_seq_ctrl_if.slave  cmd,
  input  logic             pause,
  input  logic [WIDTH-1:0] Q_in,
  output logic [1:0]       S,
  output logic             DS,
  output logic [WIDTH-1:0] D
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_ROTR = 2'b11;

  localparam logic [1:0] S_HOLD  = 2'b00;
  localparam logic [1:0] S_RIGHT = 2'b01;
  localparam logic [1:0] S_LEFT  = 2'b10;
  localparam logic [1:0] S_LOAD  = 2'b11;

  logic [1:0]       state;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] rem_q;
  logic [WIDTH-1:0] data_q;
  logic             fill_q;
  logic             done_q;
  logic [WIDTH-1:0] q_out_q;
  logic             accept;
  logic             shifting;

  assign accept        = cmd.cmd_valid && (state == ST_IDLE);
  assign cmd.cmd_ready = (state == ST_IDLE);
  assign cmd.busy      = (state != ST_IDLE);
  assign cmd.done      = done_q;
  assign cmd.q_out     = q_out_q;

  always_ff @(posedge CP or negedge CR_n) begin
    if (!CR_n) begin
      state   <= ST_IDLE;
      op_q    <= OP_LOAD;
      rem_q   <= '0;
      data_q  <= '0;
      fill_q  <= 1'b0;
      done_q  <= 1'b0;
      q_out_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q   <= cmd.cmd_op;
            data_q <= cmd.cmd_data;
            fill_q <= cmd.cmd_fill;
            // LOAD always takes exactly one RUN cycle; a zero shift count skips RUN.
            if (cmd.cmd_op == OP_LOAD) begin
              rem_q <= CNT_W'(1);
              state <= ST_RUN;
            end else begin
              rem_q <= cmd.cmd_cnt;
              state <= (cmd.cmd_cnt != '0) ? ST_RUN : ST_DONE;
            end
          end
        end
        ST_RUN: begin
          if (!pause) begin
            rem_q <= rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Q_in now reflects the last shifter edge of the command.
          q_out_q <= Q_in;
          done_q  <= 1'b1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign shifting = (state == ST_RUN) && !pause;

  // Shifter pins are decoded from state so reset forces S=hold immediately.
  always_comb begin
    S  = S_HOLD;
    DS = 1'b0;
    D  = '0;
    if (shifting) begin
      case (op_q)
        OP_LOAD: begin
          S = S_LOAD;
          D = data_q;
        end
        OP_SHR: begin
          S  = S_RIGHT;
          DS = fill_q;
        end
        OP_SHL: begin
          S  = S_LEFT;
          DS = fill_q;
        end
        OP_ROTR: begin
          S  = S_RIGHT;
          DS = Q_in[WIDTH-1];
        end
        default: S = S_HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_hc194_seq_ctrl.sv
// Directed bench for hc194_seq_ctrl driving a behavioural 74HC194 model.
module tb_hc194_seq_ctrl;
  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             CP;
  logic             CR_n;
  logic             pause;
  logic [WIDTH-1:0] Q;
  logic [1:0]       S;
  logic             DS;
  logic [WIDTH-1:0] D;

  int tests;
  int fails;

  hc194_seq_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  hc194_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CP    (CP),
    .CR_n  (CR_n),
    .cmd   (bus),
    .pause (pause),
    .Q_in  (Q),
    .S     (S),
    .DS    (DS),
    .D     (D)
  );

  // Shifter model sharing clock and reset with the controller.
  always_ff @(posedge CP or negedge CR_n) begin
    if (!CR_n) Q <= '0;
    else begin
      case (S)
        2'b01:   Q <= {Q[WIDTH-2:0], DS};
        2'b10:   Q <= {DS, Q[WIDTH-1:1]};
        2'b11:   Q <= D;
        default: Q <= Q;
      endcase
    end
  end

  initial CP = 1'b0;
  always #5 CP = ~CP;

  // Issues one command from IDLE (called #1 after an edge) and watches until done.
  // lat = edges from accept to done high (-1 on timeout); nXX = cycles with S=XX;
  // bad = cycles where pins were wrong for the op / pause state.
  task automatic run_cmd(input logic [1:0] op, input logic [2:0] cnt,
                         input logic [3:0] data, input logic fill,
                         input logic [7:0] pmask,
                         output int lat, output int n01, output int n10,
                         output int n11, output int bad);
    lat = -1; n01 = 0; n10 = 0; n11 = 0; bad = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_cnt   = cnt;
    bus.cmd_data  = data;
    bus.cmd_fill  = fill;
    @(posedge CP); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 4'b0000;
    bus.cmd_fill  = 1'b0;
    for (int n = 0; n < 40; n++) begin
      pause = (n < 8) ? pmask[n] : 1'b0;
      #1;
      if (bus.done) begin
        lat = n;
        break;
      end
      case (S)
        2'b01:   n01++;
        2'b10:   n10++;
        2'b11:   n11++;
        default: ;
      endcase
      if (S != 2'b11 && D != 4'b0000) bad++;
      if (S == 2'b11 && D != data) bad++;
      if (S == 2'b00 && DS != 1'b0) bad++;
      if (pause && S != 2'b00) bad++;
      if (op != 2'b11 && S != 2'b00 && S != 2'b11 && DS != fill) bad++;
      @(posedge CP); #1;
    end
    pause = 1'b0;
  endtask

  task automatic test_reset;
    CR_n = 1'b0;
    #20;
    tests++; if (S !== 2'b00) begin fails++; $display("FAIL reset_S got %b want 00", S); end
    tests++; if (bus.done !== 1'b0 || bus.q_out !== 4'b0000) begin fails++;
      $display("FAIL reset_out got done=%b q_out=%b want 0/0000", bus.done, bus.q_out); end
    tests++; if (D !== 4'b0000 || DS !== 1'b0 || bus.busy !== 1'b0) begin fails++;
      $display("FAIL reset_pins got D=%b DS=%b busy=%b want 0000/0/0", D, DS, bus.busy); end
    #12;
    CR_n = 1'b1;
    @(posedge CP); #1;
    tests++; if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin fails++;
      $display("FAIL reset_release got ready=%b busy=%b want 1/0", bus.cmd_ready, bus.busy); end
  endtask

  task automatic test_load;
    int lat, n01, n10, n11, bad;
    run_cmd(2'b00, 3'd5, 4'b1101, 1'b0, 8'h00, lat, n01, n10, n11, bad);
    tests++; if (lat != 2) begin fails++; $display("FAIL load_latency got %0d want 2", lat); end
    tests++; if (n11 != 1 || n01 + n10 != 0) begin fails++;
      $display("FAIL load_S got n11=%0d nshift=%0d want 1/0", n11, n01 + n10); end
    tests++; if (bad != 0) begin fails++; $display("FAIL load_pins got %0d bad cycles want 0", bad); end
    tests++; if (bus.q_out !== 4'b1101) begin fails++; $display("FAIL load_q got %b want 1101", bus.q_out); end
    tests++; if (bus.cmd_ready !== 1'b1) begin fails++; $display("FAIL ready_at_done got %b want 1", bus.cmd_ready); end
    @(posedge CP); #1;
    tests++; if (bus.done !== 1'b0 || bus.q_out !== 4'b1101) begin fails++;
      $display("FAIL done_pulse got done=%b q_out=%b want 0/1101", bus.done, bus.q_out); end
  endtask

  task automatic test_shift;
    int lat, n01, n10, n11, bad;
    run_cmd(2'b01, 3'd3, 4'b1111, 1'b0, 8'h00, lat, n01, n10, n11, bad);
    tests++; if (lat != 4 || n01 != 3 || n10 + n11 != 0) begin fails++;
      $display("FAIL shr_timing got lat=%0d n01=%0d other=%0d want 4/3/0", lat, n01, n10 + n11); end
    tests++; if (bus.q_out !== 4'b1000 || bad != 0) begin fails++;
      $display("FAIL shr_q got %b bad=%0d want 1000/0", bus.q_out, bad); end
    run_cmd(2'b10, 3'd2, 4'b0000, 1'b1, 8'h00, lat, n01, n10, n11, bad);
    tests++; if (lat != 3 || n10 != 2 || n01 + n11 != 0) begin fails++;
      $display("FAIL shl_timing got lat=%0d n10=%0d other=%0d want 3/2/0", lat, n10, n01 + n11); end
    tests++; if (bus.q_out !== 4'b1110 || bad != 0) begin fails++;
      $display("FAIL shl_q got %b bad=%0d want 1110/0", bus.q_out, bad); end
  endtask

  task automatic test_rotate;
    int lat, n01, n10, n11, bad;
    run_cmd(2'b00, 3'd0, 4'b1101, 1'b0, 8'h00, lat, n01, n10, n11, bad);
    run_cmd(2'b11, 3'd1, 4'b0000, 1'b0, 8'h00, lat, n01, n10, n11, bad);
    tests++; if (lat != 2 || bus.q_out !== 4'b1011 || bad != 0) begin fails++;
      $display("FAIL rotr1 got lat=%0d q=%b bad=%0d want 2/1011/0", lat, bus.q_out, bad); end
    run_cmd(2'b11, 3'd4, 4'b0000, 1'b0, 8'h00, lat, n01, n10, n11, bad);
    tests++; if (lat != 5 || n01 != 4 || bus.q_out !== 4'b1011) begin fails++;
      $display("FAIL rotr4 got lat=%0d n01=%0d q=%b want 5/4/1011", lat, n01, bus.q_out); end
    run_cmd(2'b01, 3'd0, 4'b0000, 1'b1, 8'h00, lat, n01, n10, n11, bad);
    tests++; if (lat != 1 || n01 + n10 + n11 != 0 || bus.q_out !== 4'b1011) begin fails++;
      $display("FAIL cnt0 got lat=%0d act=%0d q=%b want 1/0/1011", lat, n01 + n10 + n11, bus.q_out); end
  endtask

  task automatic test_pause;
    int lat, n01, n10, n11, bad;
    run_cmd(2'b00, 3'd0, 4'b1101, 1'b0, 8'h00, lat, n01, n10, n11, bad);
    // Pause cycles 1 and 2 after the accept edge: right after the first shift.
    run_cmd(2'b01, 3'd3, 4'b0000, 1'b0, 8'b0000_0110, lat, n01, n10, n11, bad);
    tests++; if (lat != 6 || n01 != 3) begin fails++;
      $display("FAIL pause_timing got lat=%0d n01=%0d want 6/3", lat, n01); end
    tests++; if (bus.q_out !== 4'b1000 || bad != 0) begin fails++;
      $display("FAIL pause_q got %b bad=%0d want 1000/0", bus.q_out, bad); end
  endtask

  task automatic test_reset_mid;
    int lat, n01, n10, n11, bad;
    int seen_done;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b01;
    bus.cmd_cnt   = 3'd3;
    bus.cmd_fill  = 1'b1;
    @(posedge CP); #1;
    bus.cmd_valid = 1'b0;
    @(posedge CP); #1;
    tests++; if (S !== 2'b01 || bus.busy !== 1'b1) begin fails++;
      $display("FAIL mid_running got S=%b busy=%b want 01/1", S, bus.busy); end
    CR_n = 1'b0;
    #1;
    tests++; if (S !== 2'b00 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin fails++;
      $display("FAIL mid_reset got S=%b busy=%b ready=%b want 00/0/1", S, bus.busy, bus.cmd_ready); end
    #2;
    CR_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge CP); #1;
      if (bus.done || bus.busy) seen_done++;
    end
    tests++; if (seen_done != 0 || bus.q_out !== 4'b0000) begin fails++;
      $display("FAIL mid_no_done got %0d active cycles q=%b want 0/0000", seen_done, bus.q_out); end
    run_cmd(2'b00, 3'd0, 4'b0110, 1'b0, 8'h00, lat, n01, n10, n11, bad);
    tests++; if (lat != 2 || bus.q_out !== 4'b0110) begin fails++;
      $display("FAIL mid_recover got lat=%0d q=%b want 2/0110", lat, bus.q_out); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    pause = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_cnt   = 3'd0;
    bus.cmd_data  = 4'b0000;
    bus.cmd_fill  = 1'b0;
    test_reset();
    test_load();
    test_shift();
    test_rotate();
    test_pause();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
